// File: rtl/gb_length_unit.sv
// gb_length_unit: per-channel APU length counters sharing one 256 Hz length clock.
// Revision: 1.0
`default_nettype none

module gb_length_unit #(
  parameter int                NUM_CH    = 4,
  parameter int                W_SHORT   = 6,
  parameter int                W_LONG    = 8,
  parameter logic [NUM_CH-1:0] LONG_MASK = 4'b0100
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_tick,
  input  logic [NUM_CH-1:0]            load,
  input  logic [NUM_CH*W_LONG-1:0]     load_val,
  input  logic [NUM_CH-1:0]            len_en_wr,
  input  logic [NUM_CH-1:0]            len_en_val,
  input  logic [NUM_CH-1:0]            trigger,
  input  logic [NUM_CH-1:0]            dac_en,
  output logic [NUM_CH-1:0]            active,
  output logic [NUM_CH*(W_LONG+1)-1:0] remaining,
  output logic                         len_clk
);

  logic [2:0] r_step;
  logic       r_half;
  logic       r_len_clk;
  logic       w_len_tick;

  // Even pre-increment step means this frame tick clocks length.
  assign w_len_tick = frame_tick & ~r_step[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_step    <= 3'd0;
      r_half    <= 1'b0;
      r_len_clk <= 1'b0;
    end else begin
      r_len_clk <= w_len_tick;
      if (frame_tick) begin
        r_step <= r_step + 3'd1;
        r_half <= w_len_tick;
      end
    end
  end

  assign len_clk = r_len_clk;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam int              W_I      = LONG_MASK[gi] ? W_LONG : W_SHORT;
    localparam logic [W_LONG:0] c_one    = (W_LONG+1)'(1);
    localparam logic [W_LONG:0] c_max    = (W_LONG+1)'(1 << W_I);
    localparam logic [W_LONG:0] c_max_m1 = c_max - c_one;
    localparam logic [W_LONG-1:0] c_mask = c_max_m1[W_LONG-1:0];

    logic              r_en;
    logic              r_act;
    logic [W_LONG:0]   r_rem;
    logic [W_LONG-1:0] w_slice;
    logic [W_LONG:0]   w_v0;
    logic [W_LONG:0]   w_v1;
    logic [W_LONG:0]   w_v2;
    logic [W_LONG:0]   w_v3;
    logic              w_en_new;
    logic              w_extra;
    logic              w_tdec;
    logic              w_hit0;
    logic              w_act;

    // Running value: load, then extra clock, then length tick, then trigger reload.
    assign w_slice  = load_val[gi*W_LONG +: W_LONG] & c_mask;
    assign w_v0     = load[gi] ? (c_max - {1'b0, w_slice}) : r_rem;
    assign w_en_new = len_en_wr[gi] ? len_en_val[gi] : r_en;
    assign w_extra  = len_en_wr[gi] & len_en_val[gi] & ~r_en & r_half & (w_v0 != '0);
    assign w_v1     = w_extra ? (w_v0 - c_one) : w_v0;
    assign w_tdec   = w_len_tick & r_en & (w_v1 != '0);
    assign w_v2     = w_tdec ? (w_v1 - c_one) : w_v1;
    assign w_hit0   = (w_extra & (w_v1 == '0)) | (w_tdec & (w_v2 == '0));
    assign w_v3     = (trigger[gi] & (w_v2 == '0)) ?
                      ((w_en_new & r_half) ? c_max_m1 : c_max) : w_v2;
    assign w_act    = dac_en[gi] & (trigger[gi] | (r_act & ~w_hit0));

    always_ff @(posedge clk) begin
      if (reset) begin
        r_en  <= 1'b0;
        r_act <= 1'b0;
        r_rem <= '0;
      end else begin
        r_en  <= w_en_new;
        r_act <= w_act;
        r_rem <= w_v3;
      end
    end

    assign active[gi]                            = r_act;
    assign remaining[gi*(W_LONG+1) +: W_LONG+1] = r_rem;
  end

endmodule

`default_nettype wire

// File: tb/tb_gb_length_unit.sv
// tb_gb_length_unit: directed scoreboard bench for gb_length_unit.
// Revision: 1.0
`default_nettype none

module tb_gb_length_unit;

  logic        clk;
  logic        reset;
  logic        frame_tick;
  logic [3:0]  load;
  logic [31:0] load_val;
  logic [3:0]  len_en_wr;
  logic [3:0]  len_en_val;
  logic [3:0]  trigger;
  logic [3:0]  dac_en;
  logic [3:0]  active;
  logic [35:0] remaining;
  logic        len_clk;

  gb_length_unit dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .load       (load),
    .load_val   (load_val),
    .len_en_wr  (len_en_wr),
    .len_en_val (len_en_val),
    .trigger    (trigger),
    .dac_en     (dac_en),
    .active     (active),
    .remaining  (remaining),
    .len_clk    (len_clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  act;
    logic [35:0] rem;
    logic        lc;
  } exp_t;

  exp_t  q_exp[$];
  string q_tag[$];
  int    errors = 0;
  int    checks = 0;

  // Expected architectural state tracked by the bench.
  logic [8:0] e_rem [4];
  logic [3:0] e_act;
  logic [3:0] e_en;
  logic       e_lc;
  logic       e_half;
  int         e_step;

  task automatic clr_strobes();
    load       = '0;
    load_val   = '0;
    len_en_wr  = '0;
    len_en_val = '0;
    trigger    = '0;
  endtask

  task automatic e_reset();
    for (int c = 0; c < 4; c++) e_rem[c] = '0;
    e_act  = '0;
    e_en   = '0;
    e_lc   = 1'b0;
    e_half = 1'b0;
    e_step = 0;
  endtask

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock; when chk is set the expected snapshot is queued before the edge.
  task automatic step(input bit chk, input string tag);
    exp_t e;
    exp_t got;
    string t;
    if (chk) begin
      e.act = e_act;
      e.lc  = e_lc;
      for (int c = 0; c < 4; c++) e.rem[c*9 +: 9] = e_rem[c];
      q_exp.push_back(e);
      q_tag.push_back(tag);
    end
    @(posedge clk);
    #1;
    if (chk) begin
      got = q_exp.pop_front();
      t   = q_tag.pop_front();
      cmp({t, ".active"},    64'(active),    64'(got.act));
      cmp({t, ".remaining"}, 64'(remaining), 64'(got.rem));
      cmp({t, ".len_clk"},   64'(len_clk),   64'(got.lc));
    end
  endtask

  // Frame-sequencer tick (plus any strobes already set), then one idle cycle.
  task automatic frame(input string tag);
    e_lc = (e_step % 2 == 0);
    if (e_lc) begin
      for (int c = 0; c < 4; c++) begin
        if (e_en[c] && e_rem[c] != 0) begin
          e_rem[c] = e_rem[c] - 9'd1;
          if (e_rem[c] == 0) e_act[c] = 1'b0;
        end
      end
    end
    e_half = e_lc;
    e_step = (e_step + 1) % 8;
    frame_tick = 1'b1;
    step(1, tag);
    frame_tick = 1'b0;
    clr_strobes();
    e_lc = 1'b0;
    step(1, {tag, "_idle"});
  endtask

  initial begin
    reset      = 1'b1;
    frame_tick = 1'b0;
    dac_en     = 4'hF;
    clr_strobes();
    e_reset();
    step(0, "");
    step(1, "reset");
    reset = 1'b0;

    // ch0: load 60 with length enable and trigger -> 4 remaining
    load[0] = 1'b1; load_val[7:0] = 8'd60;
    len_en_wr[0] = 1'b1; len_en_val[0] = 1'b1; trigger[0] = 1'b1;
    e_rem[0] = 9'd4; e_act[0] = 1'b1; e_en[0] = 1'b1;
    step(1, "ch0_load");
    clr_strobes();
    for (int k = 0; k < 8; k++) frame($sformatf("ch0_frame%0d", k + 1));

    // ch2 long: load 0, trigger with length disabled -> 256
    load[2] = 1'b1; load_val[23:16] = 8'd0; trigger[2] = 1'b1;
    len_en_wr[2] = 1'b1; len_en_val[2] = 1'b0;
    e_rem[2] = 9'd256; e_act[2] = 1'b1;
    step(1, "ch2_load");
    clr_strobes();
    len_en_wr[2] = 1'b1; len_en_val[2] = 1'b1;
    e_en[2] = 1'b1;
    step(1, "ch2_enable_half0");
    clr_strobes();
    for (int k = 0; k < 512; k++) frame("ch2_count");
    cmp("ch2_final_rem", 64'(remaining[26:18]), 64'd0);
    cmp("ch2_final_act", 64'(active[2]), 64'd0);

    // ch1 extra clocking: remaining 1, half 1, enable 0->1
    load[1] = 1'b1; load_val[15:8] = 8'd63; trigger[1] = 1'b1;
    e_rem[1] = 9'd1; e_act[1] = 1'b1;
    step(1, "ch1_load");
    clr_strobes();
    frame("ch1_sethalf");
    len_en_wr[1] = 1'b1; len_en_val[1] = 1'b1;
    e_rem[1] = 9'd0; e_act[1] = 1'b0; e_en[1] = 1'b1;
    step(1, "ch1_extra_kill");
    clr_strobes();
    load[1] = 1'b1; load_val[15:8] = 8'd63;
    len_en_wr[1] = 1'b1; len_en_val[1] = 1'b0;
    e_rem[1] = 9'd1; e_en[1] = 1'b0;
    step(1, "ch1_reload1");
    clr_strobes();
    len_en_wr[1] = 1'b1; len_en_val[1] = 1'b1; trigger[1] = 1'b1;
    e_rem[1] = 9'd63; e_act[1] = 1'b1; e_en[1] = 1'b1;
    step(1, "ch1_extra_trig");
    clr_strobes();

    // Trigger reload values
    trigger[3] = 1'b1;
    e_rem[3] = 9'd64; e_act[3] = 1'b1;
    step(1, "ch3_trig_len0");
    clr_strobes();
    trigger[0] = 1'b1;
    e_rem[0] = 9'd63; e_act[0] = 1'b1;
    step(1, "ch0_trig_len1_half1");
    clr_strobes();
    dac_en[2] = 1'b0; trigger[2] = 1'b1;
    e_rem[2] = 9'd255; e_act[2] = 1'b0;
    step(1, "ch2_trig_dac_off");
    clr_strobes();
    dac_en[2] = 1'b1;

    // Frame tick coincident with load on ch3
    frame("odd_frame");
    len_en_wr[3] = 1'b1; len_en_val[3] = 1'b1;
    e_en[3] = 1'b1;
    step(1, "ch3_enable");
    clr_strobes();
    load[3] = 1'b1; load_val[31:24] = 8'd10;
    e_rem[3] = 9'd54;
    frame("ch3_load_tick");
    dac_en[3] = 1'b0; trigger[3] = 1'b1;
    e_act[3] = 1'b0;
    step(1, "ch3_dac_fall_trig");
    clr_strobes();
    dac_en[3] = 1'b1;

    // Reset mid-countdown, then verify the step counter restarted at 0
    trigger = 4'hF;
    e_act = 4'hF;
    step(1, "all_trig");
    clr_strobes();
    reset = 1'b1;
    e_reset();
    step(1, "mid_reset");
    reset = 1'b0;
    load[0] = 1'b1; load_val[7:0] = 8'd62;
    len_en_wr[0] = 1'b1; len_en_val[0] = 1'b1; trigger[0] = 1'b1;
    e_rem[0] = 9'd2; e_act[0] = 1'b1; e_en[0] = 1'b1;
    step(1, "post_reset_load");
    clr_strobes();
    for (int k = 0; k < 3; k++) frame($sformatf("post_reset_frame%0d", k + 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
